// File: rtl/ram_loader_pkg.sv
// -----------------------------------------------------------------------------
// ram_loader_pkg
// Shared definitions for the sequential scratch-RAM writer:
//   - state_t      : write-cycle FSM states (RDBK/CMP are used only when the
//                    read-back verify build macro RAM_LOADER_VERIFY_EN is set)
//   - ADDR_W_DEF   : default RAM address width
//   - DATA_W_DEF   : default RAM word width
//   - DEPTH        : default RAM depth, 2**ADDR_W_DEF
//   - COUNT_SAT    : default saturation value of the word counter
//   - count_sat()  : saturation value for an arbitrary address width
// -----------------------------------------------------------------------------
package ram_loader_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH      = 1 << ADDR_W_DEF;

  // The counter stops at the RAM depth, so a full pass is distinguishable
  // from an empty one even though the pointer has wrapped back.
  function automatic int unsigned count_sat(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  localparam int unsigned COUNT_SAT = count_sat(ADDR_W_DEF);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,  // waiting for a word or a pointer load
    S_SETUP  = 3'd1,  // address/data driven, write strobe still low
    S_STROBE = 3'd2,  // write strobe high for exactly one cycle
    S_HOLD   = 3'd3,  // strobe low, address/data held
    S_RDBK   = 3'd4,  // RAM registers the word at the held address
    S_CMP    = 3'd5   // compare registered read data against the written word
  } state_t;

endpackage

// File: rtl/ram_loader_if.sv
// -----------------------------------------------------------------------------
// ram_loader_if
// Bundles the word-stream handshake and the RAM port of ram_loader.
//   in_valid  : source presents a word
//   in_data   : word to be written
//   in_ready  : loader can accept a word this cycle
//   mem_addr  : RAM address
//   mem_data  : RAM write data
//   mem_we    : RAM write enable
//   mem_q     : RAM registered read data (only consumed by the verify build)
// Modports:
//   slave  : the loader (accepts the stream, drives the RAM port)
//   master : the environment (word source plus RAM)
// -----------------------------------------------------------------------------
interface ram_loader_if
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  in_valid, in_data, mem_q,
    output in_ready, mem_addr, mem_data, mem_we
  );

  modport master (
    output in_valid, in_data, mem_q,
    input  in_ready, mem_addr, mem_data, mem_we
  );

endinterface

// File: rtl/ram_loader_ptr.sv
// -----------------------------------------------------------------------------
// ram_loader_ptr
// Write pointer and word counter of the RAM loader.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   load       : set wr_ptr to start_addr and clear the counter
//   advance    : a word has been written; step pointer and counter
//   start_addr : pointer load value
//   wr_ptr     : next address to be written (wraps modulo 2**ADDR_W)
//   count      : words written since load/reset, saturating at 2**ADDR_W
//   full       : counter saturated and WRAP == 0
// Parameter WRAP: 0 = report full after one pass, 1 = never report full.
// -----------------------------------------------------------------------------
module ram_loader_ptr
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam int unsigned   SAT_I   = count_sat(ADDR_W);
  localparam logic [ADDR_W:0] CNT_MAX = SAT_I[ADDR_W:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering; the reset is
  // asynchronous, hence its presence in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (load) begin
      wr_ptr <= start_addr;
      count  <= '0;
    end else if (advance) begin
      // The pointer relies on natural modulo-2**ADDR_W overflow.
      wr_ptr <= wr_ptr + 1'b1;
      if (count != CNT_MAX) begin
        count <= count + 1'b1;
      end
    end
  end

  // Derived from the counter, so a load clears it in the same edge.
  assign full = (WRAP == 0) && (count == CNT_MAX);

endmodule

// File: rtl/ram_loader.sv
// -----------------------------------------------------------------------------
// ram_loader
// Sequential writer for a synchronous single-port scratch RAM. Words arrive
// over a valid/ready handshake and are written to consecutive addresses with
// a setup / strobe / hold write cycle; the pointer can be reloaded.
//
// Ports:
//   CLOCK_50   : system clock, all state on the rising edge
//   reset      : asynchronous active-high reset
//   bus        : ram_loader_if.slave (word stream in, RAM port out)
//   load_addr  : pulse, in IDLE loads the pointer with start_addr
//   start_addr : pointer load value
//   wr_ptr     : next address to be written
//   count      : words written since load/reset (saturating)
//   full       : one complete pass written and WRAP == 0
//   err        : sticky read-back mismatch flag
//   err_addr   : address of the first mismatch
//
// Build option RAM_LOADER_VERIFY_EN: when defined, every word is read back
// (RDBK, CMP) and compared, giving a 6-cycle word time; otherwise the word
// time is 4 cycles, mem_q is ignored and err/err_addr are tied to 0.
// -----------------------------------------------------------------------------
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WRAP   = 0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  ram_loader_if.slave       bus,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nx;
  logic [DATA_W-1:0] mem_data_q, mem_data_nx;
  logic              mem_we_q, mem_we_nx;
  logic              ready;
  logic              ptr_load;
  logic              ptr_adv;

  ram_loader_ptr #(
    .ADDR_W (ADDR_W),
    .WRAP   (WRAP)
  ) u_ptr (
    .clk        (CLOCK_50),
    .rst        (reset),
    .load       (ptr_load),
    .advance    (ptr_adv),
    .start_addr (start_addr),
    .wr_ptr     (wr_ptr),
    .count      (count),
    .full       (full)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_nx    = state;
    mem_addr_nx = mem_addr_q;
    mem_data_nx = mem_data_q;
    mem_we_nx   = 1'b0;
    ready       = 1'b0;
    ptr_load    = 1'b0;
    ptr_adv     = 1'b0;

    case (state)
      S_IDLE: begin
        // A load in the same cycle as a valid word wins; the word stays
        // pending at the source because ready is held low.
        ready = ~full & ~load_addr;
        if (load_addr) begin
          ptr_load = 1'b1;
        end else if (bus.in_valid && ready) begin
          mem_addr_nx = wr_ptr;
          mem_data_nx = bus.in_data;
          state_nx    = S_SETUP;
        end
      end

      S_SETUP: begin
        mem_we_nx = 1'b1;
        state_nx  = S_STROBE;
      end

      // Strobe drops on this edge; address and data stay put for a full
      // hold cycle after the RAM has captured them.
      S_STROBE: begin
        state_nx = S_HOLD;
      end

      S_HOLD: begin
`ifdef RAM_LOADER_VERIFY_EN
        state_nx = S_RDBK;
`else
        ptr_adv  = 1'b1;
        state_nx = S_IDLE;
`endif
      end

`ifdef RAM_LOADER_VERIFY_EN
      // The held address is presented for one more edge so the RAM's
      // registered output holds the just-written word by the CMP cycle.
      S_RDBK: begin
        state_nx = S_CMP;
      end

      S_CMP: begin
        ptr_adv  = 1'b1;
        state_nx = S_IDLE;
      end
`endif

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and RAM-port registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      mem_addr_q <= mem_addr_nx;
      mem_data_q <= mem_data_nx;
      mem_we_q   <= mem_we_nx;
    end
  end

  assign bus.in_ready = ready;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_we   = mem_we_q;

  // ---------------------------------------------------------------------------
  // Read-back verify
  // ---------------------------------------------------------------------------
`ifdef RAM_LOADER_VERIFY_EN
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic              mismatch;

  // Only the first mismatch is recorded; later ones leave err_addr alone.
  assign mismatch = (state == S_CMP) && (bus.mem_q != mem_data_q) && !err_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (ptr_load) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (mismatch) begin
      err_q      <= 1'b1;
      err_addr_q <= mem_addr_q;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  assign err      = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_ram_loader
// Directed bench for ram_loader. Two instances share the clock and reset:
// u_dut0 with WRAP=0 and u_dut1 with WRAP=1; 'sel' routes the shared
// stimulus to one of them and muxes its outputs onto the observed signals.
// Each instance has its own RAM model with registered read data; the RAM of
// u_dut0 can force bit 0 high on addresses 5 and 9 for the verify build.
// -----------------------------------------------------------------------------
module tb_ram_loader;
  import ram_loader_pkg::*;

  localparam int AW = 5;
  localparam int DW = 4;
`ifdef RAM_LOADER_VERIFY_EN
  localparam int CYC = 6;
`else
  localparam int CYC = 4;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b1;
  logic          sel      = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          load_addr = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          stuck_en = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  ram_loader_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  ram_loader_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

  logic          load0, load1;
  logic [AW-1:0] wr_ptr0, wr_ptr1, err_addr0, err_addr1;
  logic [AW:0]   count0, count1;
  logic          full0, full1, err0, err1;
  logic [DW-1:0] q0, q1;

  assign load0        = load_addr & ~sel;
  assign load1        = load_addr & sel;
  assign if0.in_valid = in_valid & ~sel;
  assign if1.in_valid = in_valid & sel;
  assign if0.in_data  = in_data;
  assign if1.in_data  = in_data;
  assign if0.mem_q    = q0;
  assign if1.mem_q    = q1;

  ram_loader #(.ADDR_W(AW), .DATA_W(DW), .WRAP(0)) u_dut0 (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .bus        (if0),
    .load_addr  (load0),
    .start_addr (start_addr),
    .wr_ptr     (wr_ptr0),
    .count      (count0),
    .full       (full0),
    .err        (err0),
    .err_addr   (err_addr0)
  );

  ram_loader #(.ADDR_W(AW), .DATA_W(DW), .WRAP(1)) u_dut1 (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .bus        (if1),
    .load_addr  (load1),
    .start_addr (start_addr),
    .wr_ptr     (wr_ptr1),
    .count      (count1),
    .full       (full1),
    .err        (err1),
    .err_addr   (err_addr1)
  );

  // Observed view of the selected instance.
  logic          rdy, we, fl, er;
  logic [AW-1:0] maddr, ptr, eaddr;
  logic [DW-1:0] mdata;
  logic [AW:0]   cnt;

  assign rdy   = sel ? if1.in_ready : if0.in_ready;
  assign we    = sel ? if1.mem_we   : if0.mem_we;
  assign maddr = sel ? if1.mem_addr : if0.mem_addr;
  assign mdata = sel ? if1.mem_data : if0.mem_data;
  assign ptr   = sel ? wr_ptr1      : wr_ptr0;
  assign cnt   = sel ? count1       : count0;
  assign fl    = sel ? full1        : full0;
  assign er    = sel ? err1         : err0;
  assign eaddr = sel ? err_addr1    : err_addr0;

  // RAM models: write on the edge where mem_we is high, registered read.
  logic [DW-1:0] ram0 [0:31];
  logic [DW-1:0] ram1 [0:31];

  always @(posedge CLOCK_50) begin
    if (if0.mem_we) begin
      if (stuck_en && (if0.mem_addr == 5'd5 || if0.mem_addr == 5'd9))
        ram0[if0.mem_addr] <= if0.mem_data | 4'h1;
      else
        ram0[if0.mem_addr] <= if0.mem_data;
    end
    q0 <= ram0[if0.mem_addr];
    if (if1.mem_we) ram1[if1.mem_addr] <= if1.mem_data;
    q1 <= ram1[if1.mem_addr];
  end

  // Write-strobe monitors, sampled mid-cycle.
  int            we_hi0 = 0;
  int            full_seen1 = 0;
  logic [AW-1:0] last_wa0 = '0;
  logic [AW-1:0] wa1 [$];

  always @(negedge CLOCK_50) begin
    if (if0.mem_we) begin
      we_hi0++;
      last_wa0 = if0.mem_addr;
    end
    if (if1.mem_we) wa1.push_back(if1.mem_addr);
    if (full1) full_seen1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one word and returns mid-cycle once the loader is back in IDLE.
  task automatic send_word(input logic [DW-1:0] d, input bit timing);
    int            n;
    logic [AW-1:0] a;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!rdy && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 40) begin
      check("ready_timeout", 32'(rdy), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    if (timing) begin
      a = maddr;
      check("e0_we", 32'(we), 32'd0);
      check("e0_data", 32'(mdata), 32'(d));
      @(negedge CLOCK_50);
      check("e1_we", 32'(we), 32'd1);
      check("e1_addr", 32'(maddr), 32'(a));
      @(negedge CLOCK_50);
      check("e2_we", 32'(we), 32'd0);
      check("e2_addr", 32'(maddr), 32'(a));
      check("e2_data", 32'(mdata), 32'(d));
      repeat (CYC - 3) @(negedge CLOCK_50);
    end else begin
      repeat (CYC - 1) @(negedge CLOCK_50);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(rdy), 32'd1);
    check("rst_we", 32'(we), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd0);
    check("rst_count", 32'(cnt), 32'd0);
    check("rst_full", 32'(fl), 32'd0);
    check("rst_err", 32'(er), 32'd0);
    check("rst_err_addr", 32'(eaddr), 32'd0);
    check("rst_mem_addr", 32'(maddr), 32'd0);
    @(negedge CLOCK_50);

    // ---------------- three words from address 0 ----------------
    send_word(4'h3, 1'b1);
    check("w1_ready", 32'(rdy), 32'd1);
    check("w1_ptr", 32'(ptr), 32'd1);
    send_word(4'h7, 1'b0);
    send_word(4'hA, 1'b0);
    check("ram0_0", 32'(ram0[0]), 32'h3);
    check("ram0_1", 32'(ram0[1]), 32'h7);
    check("ram0_2", 32'(ram0[2]), 32'hA);
    check("we_pulses3", 32'(we_hi0), 32'd3);
    check("count3", 32'(cnt), 32'd3);
    check("ptr3", 32'(ptr), 32'd3);

    // ---------------- load and valid in the same IDLE cycle ----------------
    start_addr = 5'd30;
    load_addr  = 1'b1;
    in_data    = 4'h5;
    in_valid   = 1'b1;
    #1;
    check("load_ready", 32'(rdy), 32'd0);
    @(negedge CLOCK_50);
    load_addr = 1'b0;
    in_valid  = 1'b0;
    check("load_ptr", 32'(ptr), 32'd30);
    check("load_count", 32'(cnt), 32'd0);
    check("load_we", 32'(we), 32'd0);
    @(negedge CLOCK_50);
    check("load_no_write", 32'(we_hi0), 32'd3);
    check("load_idle_ready", 32'(rdy), 32'd1);

    // ---------------- WRAP=0 pass starting at 30 ----------------
    send_word(4'h1, 1'b0);
    send_word(4'h2, 1'b0);
    send_word(4'h3, 1'b0);
    check("ram0_30", 32'(ram0[30]), 32'h1);
    check("ram0_31", 32'(ram0[31]), 32'h2);
    check("ram0_0b", 32'(ram0[0]), 32'h3);
    check("ptr_wrap", 32'(ptr), 32'd1);
    check("count_wrap", 32'(cnt), 32'd3);
    for (int i = 3; i < 32; i++) send_word(4'(i), 1'b0);
    check("full_count", 32'(cnt), 32'd32);
    check("full_flag", 32'(fl), 32'd1);
    check("full_ready", 32'(rdy), 32'd0);
    check("full_ptr", 32'(ptr), 32'd30);
    check("full_we_pulses", 32'(we_hi0), 32'd35);
    in_data  = 4'hF;
    in_valid = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    in_valid = 1'b0;
    check("full_no_write", 32'(we_hi0), 32'd35);
    check("full_count_hold", 32'(cnt), 32'd32);
    start_addr = 5'd0;
    load_addr  = 1'b1;
    @(negedge CLOCK_50);
    load_addr = 1'b0;
    check("reload_full", 32'(fl), 32'd0);
    check("reload_count", 32'(cnt), 32'd0);

    // ---------------- WRAP=1, 40 words from 0 ----------------
    sel = 1'b1;
    @(negedge CLOCK_50);
    for (int i = 0; i < 40; i++) send_word(4'(i / 4), 1'b0);
    check("wrap_writes", 32'(wa1.size()), 32'd40);
    if (wa1.size() == 40) begin
      check("wrap_addr31", 32'(wa1[31]), 32'd31);
      check("wrap_addr32", 32'(wa1[32]), 32'd0);
      check("wrap_addr39", 32'(wa1[39]), 32'd7);
    end
    check("wrap_count", 32'(cnt), 32'd32);
    check("wrap_full", 32'(fl), 32'd0);
    check("wrap_full_seen", 32'(full_seen1), 32'd0);
    check("wrap_ready", 32'(rdy), 32'd1);
    check("wrap_ptr", 32'(ptr), 32'd8);
    check("ram1_1", 32'(ram1[1]), 32'd8);
    check("ram1_7", 32'(ram1[7]), 32'd9);
    check("ram1_31", 32'(ram1[31]), 32'd7);
    sel = 1'b0;
    @(negedge CLOCK_50);

    // ---------------- read-back verify ----------------
`ifdef RAM_LOADER_VERIFY_EN
    stuck_en   = 1'b1;
    start_addr = 5'd5;
    load_addr  = 1'b1;
    @(negedge CLOCK_50);
    load_addr = 1'b0;
    send_word(4'h4, 1'b0);
    check("vfy_ram5", 32'(ram0[5]), 32'h5);
    check("vfy_err", 32'(er), 32'd1);
    check("vfy_err_addr", 32'(eaddr), 32'd5);
    send_word(4'h1, 1'b0);
    send_word(4'h1, 1'b0);
    send_word(4'h1, 1'b0);
    send_word(4'h2, 1'b0);
    check("vfy_ram9", 32'(ram0[9]), 32'h3);
    check("vfy_err_sticky", 32'(er), 32'd1);
    check("vfy_err_addr_first", 32'(eaddr), 32'd5);
    check("vfy_ptr", 32'(ptr), 32'd10);
    stuck_en = 1'b0;
`else
    check("novfy_err", 32'(er), 32'd0);
    check("novfy_err_addr", 32'(eaddr), 32'd0);
`endif

    // ---------------- reset during the strobe cycle ----------------
    start_addr = 5'd12;
    load_addr  = 1'b1;
    @(negedge CLOCK_50);
    load_addr = 1'b0;
    in_data   = 4'h9;
    in_valid  = 1'b1;
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    check("pre_rst_addr", 32'(maddr), 32'd12);
    @(negedge CLOCK_50);
    check("pre_rst_we", 32'(we), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_we", 32'(we), 32'd0);
    check("rst_mid_addr", 32'(maddr), 32'd0);
    check("rst_mid_data", 32'(mdata), 32'd0);
    check("rst_mid_ptr", 32'(ptr), 32'd0);
    check("rst_mid_count", 32'(cnt), 32'd0);
    check("rst_mid_ready", 32'(rdy), 32'd1);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    send_word(4'hC, 1'b0);
    check("post_rst_waddr", 32'(last_wa0), 32'd0);
    check("post_rst_ram0", 32'(ram0[0]), 32'hC);
    check("post_rst_ptr", 32'(ptr), 32'd1);
    check("post_rst_count", 32'(cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Sequential writer for the 32x4 synchronous single-port scratch RAM, the write-side counterpart to the periodic address scanner/display reader. It accepts 4-bit words over a valid/ready handshake, typically from switch input qualified by a debounced key. It writes each word to consecutive RAM addresses with a clean setup/strobe/hold write cycle. The pointer is loadable. An optional read-back verify checks each word after it is written.

## Interface
- ADDR_W, 5: RAM address width; depth = 2**ADDR_W.
- DATA_W, 4: RAM word width.
- WRAP, 0:
  - 0: stop accepting words when full.
  - 1: pointer wraps from last address to 0 and the block never reports full.

- CLOCK_50  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  source presents a word.
- in_data  in  DATA_W  word to write.
- in_ready  out  1  block can accept a word; transfer occurs on an edge where in_valid & in_ready.
- load_addr  in  1  pulse: set pointer to start_addr.
- start_addr  in  ADDR_W  pointer load value.
- mem_addr  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM registered read data; used only with verify.
- wr_ptr  out  ADDR_W  next address to be written.
- count  out  ADDR_W+1  words written since last load/reset; saturates at 2**ADDR_W.
- full  out  1  count == 2**ADDR_W and WRAP == 0.
- err  out  1  sticky verify mismatch; constant 0 without verify.
- err_addr  out  ADDR_W  address of first mismatch; 0 without verify.

## Operation
- Reset values:
  - FSM state: IDLE.
  - wr_ptr, count, mem_addr, mem_data, err_addr: 0.
  - mem_we, full, err: 0.
  - in_ready: 1.
- States: IDLE, SETUP, STROBE, HOLD, and (verify only) RDBK, CMP.
- IDLE:
  - in_ready = ~full & ~load_addr.
  - When load_addr is high:
    - wr_ptr <= start_addr.
    - count <= 0; full <= 0.
    - err and err_addr are cleared.
    - Load takes priority over in_valid in the same cycle; no transfer occurs.
  - When a transfer occurs:
    - Capture in_data.
    - mem_addr <= wr_ptr; mem_data <= in_data.
    - Go to SETUP.
- SETUP → STROBE: mem_we <= 1.
- STROBE → HOLD: mem_we <= 0; mem_addr and mem_data stay unchanged.
- HOLD, without verify → IDLE:
  - wr_ptr <= wr_ptr + 1, modulo depth.
  - count <= count + 1, saturating.
  - full is updated.
- HOLD, with verify → RDBK; mem_addr is held.
- RDBK → CMP: the RAM registers mem_q for the held address.
- CMP → IDLE:
  - If mem_q != mem_data and err == 0: err <= 1, err_addr <= mem_addr.
  - The pointer and count update as in HOLD.
- in_ready is 0 in every state except IDLE.
- load_addr outside IDLE is ignored; it is not queued.
- Width rules:
  - wr_ptr wraps naturally at 2**ADDR_W.
  - count is ADDR_W+1 bits and never exceeds 2**ADDR_W.
- WRAP=0 with the last address written:
  - count reaches 32, full = 1, in_ready = 0.
  - wr_ptr reads 0 but no write occurs until load_addr.
- WRAP=1: writes continue at 0, 1, …; count holds at 32; full stays 0.
- Non-zero start_addr with WRAP=0: full asserts after 32 writes; the pointer wraps through 0 back to start_addr.
- Reset mid-write: mem_we drops immediately and all outputs return to reset values. The interrupted word is not guaranteed written, and the source must resend it.

## Timing
- Transfer on edge E0. After E0: mem_addr/mem_data valid, mem_we = 0.
- After E1: mem_we = 1 for exactly one cycle. The RAM writes on E2.
- After E2: mem_we = 0; address and data are held for one more cycle.
- Without verify:
  - After E3: back in IDLE, wr_ptr/count updated, in_ready = 1.
  - Throughput: one word per 4 cycles.
- With verify:
  - mem_q is sampled at E5.
  - err becomes visible after E5, and in_ready = 1 after E5.
  - Throughput: one word per 6 cycles.
- mem_addr never changes while mem_we = 1. mem_data never changes within one cycle of mem_we.
- A back-to-back source holding in_valid high sees exactly one transfer per write cycle.

## Configuration
- RAM_LOADER_VERIFY_EN defined:
  - RDBK and CMP states are compiled in.
  - mem_q is used; err and err_addr are live.
  - Cycle time is 6 per word.
- Not defined:
  - HOLD returns directly to IDLE.
  - err = 0 and err_addr = 0 constant; mem_q is unconnected internally.
  - Cycle time is 4 per word.

## Structure
- Shared package ram_loader_pkg holds:
  - the state enum;
  - the default ADDR_W/DATA_W;
  - the DEPTH constant;
  - the count saturation value.
- One sub-module, ram_loader_ptr, holds wr_ptr, count and full. It takes a load strobe, an advance strobe and the WRAP parameter. The FSM and datapath stay in the top module.

## Test plan
- Reset, then write words 3, 7, 0xA from address 0 → RAM[0..2] = 3, 7, A; mem_we high exactly 1 cycle per word; count = 3; wr_ptr = 3.
- load_addr with start_addr = 30, WRAP=0, then 3 words → writes hit 30, 31, 0; after the 32nd write, full = 1 and in_ready = 0; a 33rd in_valid produces no mem_we.
- WRAP=1, 40 consecutive words from address 0 → address 31 is followed by 0; count holds 32; full stays 0.
- load_addr and in_valid high in the same IDLE cycle → pointer loaded, no write, in_ready = 0 that cycle.
- Verify build, with the RAM model forcing bit 0 stuck at 1 on address 5, writing 0x4 there → err = 1, err_addr = 5 after E5; a later mismatch at address 9 leaves err_addr = 5.
- Assert reset on the STROBE cycle → mem_we drops in the same cycle; all outputs return to reset values; the next transfer writes to address 0.
